// File: rtl/hdmi_tx_pkg.sv
// Shared TMDS definitions for the HDMI transmit path.
package hdmi_tx_pkg;

  localparam int unsigned TMDS_DATA_WIDTH = 10;

  typedef logic [TMDS_DATA_WIDTH-1:0] tmds_word_t;

  // Control-period tokens; CTL0 doubles as the filler for partially used beats.
  localparam tmds_word_t CTL0 = 10'b1101010100;
  localparam tmds_word_t CTL1 = 10'b0010101011;
  localparam tmds_word_t CTL2 = 10'b0101010100;
  localparam tmds_word_t CTL3 = 10'b1010101011;

endpackage

// File: rtl/hdmi_tx_tmds_packer.sv
// TMDS beat packer: gathers RATIO input beats per channel into one wide output beat,
// with end-of-line flush (padded, keep-masked) and start-of-frame realignment.
module hdmi_tx_tmds_packer #(
  parameter int unsigned TMDS_DATA_WIDTH = hdmi_tx_pkg::TMDS_DATA_WIDTH,
  parameter int unsigned CH_NUM          = 3,
  parameter int unsigned PIX_IN          = 1,
  parameter int unsigned RATIO           = 2,
  parameter logic [TMDS_DATA_WIDTH-1:0] PAD_WORD = hdmi_tx_pkg::CTL0,
  localparam int unsigned PIX_OUT        = PIX_IN * RATIO
) (
  input  logic                                            clk_i,
  input  logic                                            rstn_i,
  input  logic                                            s_tvalid_i,
  output logic                                            s_tready_o,
  input  logic [CH_NUM-1:0][PIX_IN-1:0][TMDS_DATA_WIDTH-1:0]  s_tdata_i,
  input  logic                                            s_tlast_i,
  input  logic                                            s_tuser_i,
  output logic                                            m_tvalid_o,
  input  logic                                            m_tready_i,
  output logic [CH_NUM-1:0][PIX_OUT-1:0][TMDS_DATA_WIDTH-1:0] m_tdata_o,
  output logic [PIX_OUT-1:0]                              m_tkeep_o,
  output logic                                            m_tlast_o,
  output logic                                            m_tuser_o,
  output logic                                            misalign_o
);
  import hdmi_tx_pkg::*;

  localparam int unsigned CntW = $clog2(RATIO);
  localparam logic [CntW-1:0] LastSlot = CntW'(RATIO - 1);

  typedef logic [CH_NUM-1:0][PIX_IN-1:0][TMDS_DATA_WIDTH-1:0]  in_beat_t;
  typedef logic [CH_NUM-1:0][PIX_OUT-1:0][TMDS_DATA_WIDTH-1:0] out_beat_t;

  logic [CntW-1:0]    cnt_q, cnt_d, slot;
  in_beat_t           acc_q [RATIO-1];
  in_beat_t           acc_d [RATIO-1];
  logic               grp_user_q, grp_user_d, grp_user_nx;
  logic               rdy_en_q;
  out_beat_t          data_q, data_d;
  logic [PIX_OUT-1:0] keep_q, keep_d;
  logic               valid_q, valid_d, last_q, last_d, user_q, user_d;
  logic               misalign_q, misalign_d;
  logic               accept, realign, launch;

  // Ready is the same for every slot: only the output register can stall us.
  assign s_tready_o  = rdy_en_q && (!valid_q || m_tready_i);
  assign accept      = s_tvalid_i && s_tready_o;
  // A frame start in mid-group throws the partial group away and restarts at slot 0.
  assign realign     = accept && s_tuser_i && (cnt_q != '0);
  assign slot        = realign ? '0 : cnt_q;
  assign launch      = accept && (s_tlast_i || (slot == LastSlot));
  assign grp_user_nx = s_tuser_i || (grp_user_q && !realign);

  // Next-state: accumulate, launch a packed beat, and drain the output register.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    grp_user_d = grp_user_q;
    data_d     = data_q;
    keep_d     = keep_q;
    valid_d    = valid_q;
    last_d     = last_q;
    user_d     = user_q;
    misalign_d = realign;
    if (valid_q && m_tready_i) valid_d = 1'b0;
    if (launch) begin
      for (int c = 0; c < CH_NUM; c++) begin
        for (int j = 0; j < PIX_OUT; j++) data_d[c][j] = PAD_WORD;
      end
      for (int k = 0; k < RATIO - 1; k++) begin
        if (k < int'(slot)) begin
          for (int c = 0; c < CH_NUM; c++) begin
            for (int p = 0; p < PIX_IN; p++) data_d[c][k*PIX_IN+p] = acc_q[k][c][p];
          end
        end
      end
      for (int k = 0; k < RATIO; k++) begin
        if (k == int'(slot)) begin
          for (int c = 0; c < CH_NUM; c++) begin
            for (int p = 0; p < PIX_IN; p++) data_d[c][k*PIX_IN+p] = s_tdata_i[c][p];
          end
        end
      end
      for (int j = 0; j < PIX_OUT; j++) keep_d[j] = (j < (int'(slot) + 1) * int'(PIX_IN));
      valid_d    = 1'b1;
      last_d     = s_tlast_i;
      user_d     = grp_user_nx;
      cnt_d      = '0;
      grp_user_d = 1'b0;
    end else if (accept) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (k == int'(slot)) acc_d[k] = s_tdata_i;
      end
      cnt_d      = slot + CntW'(1);
      grp_user_d = grp_user_nx;
    end
  end

  // State registers; everything clears asynchronously, ready comes up one edge after reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q      <= '0;
      for (int k = 0; k < RATIO - 1; k++) acc_q[k] <= '0;
      grp_user_q <= 1'b0;
      rdy_en_q   <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      user_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      grp_user_q <= grp_user_d;
      rdy_en_q   <= 1'b1;
      data_q     <= data_d;
      keep_q     <= keep_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      user_q     <= user_d;
      misalign_q <= misalign_d;
    end
  end

  assign m_tvalid_o = valid_q;
  assign m_tdata_o  = data_q;
  assign m_tkeep_o  = keep_q;
  assign m_tlast_o  = last_q;
  assign m_tuser_o  = user_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_hdmi_tx_tmds_packer.sv
// Bench for hdmi_tx_tmds_packer: instance A uses default parameters, instance B uses
// CH_NUM=4, PIX_IN=2, RATIO=3. Expected beats come from a behavioural model queue.
module tb_hdmi_tx_tmds_packer;

  localparam logic [9:0] PAD = 10'b1101010100;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // Instance A: 3 channels, 1 word in, ratio 2
  logic                  a_s_tvalid, a_s_tready, a_s_tlast, a_s_tuser;
  logic [2:0][0:0][9:0]  a_s_tdata;
  logic                  a_m_tvalid, a_m_tready, a_m_tlast, a_m_tuser, a_misalign;
  logic [2:0][1:0][9:0]  a_m_tdata;
  logic [1:0]            a_m_tkeep;

  // Instance B: 4 channels, 2 words in, ratio 3
  logic                  b_s_tvalid, b_s_tready, b_s_tlast, b_s_tuser;
  logic [3:0][1:0][9:0]  b_s_tdata;
  logic                  b_m_tvalid, b_m_tready, b_m_tlast, b_m_tuser, b_misalign;
  logic [3:0][5:0][9:0]  b_m_tdata;
  logic [5:0]            b_m_tkeep;

  hdmi_tx_tmds_packer u_dut_a (
    .clk_i(clk), .rstn_i(rstn),
    .s_tvalid_i(a_s_tvalid), .s_tready_o(a_s_tready), .s_tdata_i(a_s_tdata),
    .s_tlast_i(a_s_tlast), .s_tuser_i(a_s_tuser),
    .m_tvalid_o(a_m_tvalid), .m_tready_i(a_m_tready), .m_tdata_o(a_m_tdata),
    .m_tkeep_o(a_m_tkeep), .m_tlast_o(a_m_tlast), .m_tuser_o(a_m_tuser),
    .misalign_o(a_misalign)
  );

  hdmi_tx_tmds_packer #(.CH_NUM(4), .PIX_IN(2), .RATIO(3)) u_dut_b (
    .clk_i(clk), .rstn_i(rstn),
    .s_tvalid_i(b_s_tvalid), .s_tready_o(b_s_tready), .s_tdata_i(b_s_tdata),
    .s_tlast_i(b_s_tlast), .s_tuser_i(b_s_tuser),
    .m_tvalid_o(b_m_tvalid), .m_tready_i(b_m_tready), .m_tdata_o(b_m_tdata),
    .m_tkeep_o(b_m_tkeep), .m_tlast_o(b_m_tlast), .m_tuser_o(b_m_tuser),
    .misalign_o(b_misalign)
  );

  typedef struct {
    logic [255:0] data;
    logic [7:0]   keep;
    logic         last;
    logic         user;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_vec = 0;
  int n_fail = 0;

  // Model state per instance (0 = A, 1 = B); words stored flat as (ch*PIX_OUT + idx)*10
  int           m_cnt [2];
  logic [255:0] m_acc [2];
  logic         m_user [2];
  logic         mis_pend [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_acc[i] = '0; m_user[i] = 1'b0; mis_pend[i] = 1'b0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic model_accept(input int id, input int ch, input int pin, input int ratio,
                              input logic [255:0] din, input logic last, input logic user,
                              output logic launch, output exp_t e);
    int slot;
    int pout;
    pout = pin * ratio;
    e.data = '0; e.keep = '0; e.last = 1'b0; e.user = 1'b0;
    launch = 1'b0;
    slot = m_cnt[id];
    if (user && slot != 0) begin
      slot = 0; m_user[id] = 1'b0; mis_pend[id] = 1'b1;
    end
    for (int c = 0; c < ch; c++)
      for (int p = 0; p < pin; p++)
        m_acc[id][(c*pout + slot*pin + p)*10 +: 10] = din[(c*pin + p)*10 +: 10];
    m_user[id] = m_user[id] | user;
    if (last || slot == ratio - 1) begin
      e.data = m_acc[id];
      for (int c = 0; c < ch; c++)
        for (int k = slot + 1; k < ratio; k++)
          for (int p = 0; p < pin; p++) e.data[(c*pout + k*pin + p)*10 +: 10] = PAD;
      for (int j = 0; j < (slot + 1) * pin; j++) e.keep[j] = 1'b1;
      e.last = last;
      e.user = m_user[id];
      launch = 1'b1;
      m_cnt[id] = 0; m_acc[id] = '0; m_user[id] = 1'b0;
    end else begin
      m_cnt[id] = slot + 1;
    end
  endtask

  // Scoreboard for A: compare output beats and misalign pulses, then model accepted input.
  always @(negedge clk) begin : mon_a
    exp_t e;
    logic l;
    if (rstn === 1'b1) begin
      n_vec++;
      if (a_misalign !== mis_pend[0]) begin
        n_fail++;
        $display("FAIL a_misalign: got %b want %b", a_misalign, mis_pend[0]);
      end
      mis_pend[0] = 1'b0;
      if (a_m_tvalid && a_m_tready) begin
        n_vec++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL a_unexpected_beat: got data=%h, want no beat", a_m_tdata);
        end else begin
          e = qa.pop_front();
          if (256'(a_m_tdata) !== e.data || 8'(a_m_tkeep) !== e.keep ||
              a_m_tlast !== e.last || a_m_tuser !== e.user) begin
            n_fail++;
            $display("FAIL a_beat: got data=%h keep=%b last=%b user=%b want data=%h keep=%b last=%b user=%b",
                     a_m_tdata, a_m_tkeep, a_m_tlast, a_m_tuser, e.data[59:0], e.keep[1:0],
                     e.last, e.user);
          end
        end
      end
      if (a_s_tvalid && a_s_tready) begin
        model_accept(0, 3, 1, 2, 256'(a_s_tdata), a_s_tlast, a_s_tuser, l, e);
        if (l) qa.push_back(e);
      end
    end
  end

  // Scoreboard for B.
  always @(negedge clk) begin : mon_b
    exp_t e;
    logic l;
    if (rstn === 1'b1) begin
      n_vec++;
      if (b_misalign !== mis_pend[1]) begin
        n_fail++;
        $display("FAIL b_misalign: got %b want %b", b_misalign, mis_pend[1]);
      end
      mis_pend[1] = 1'b0;
      if (b_m_tvalid && b_m_tready) begin
        n_vec++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected_beat: got data=%h, want no beat", b_m_tdata);
        end else begin
          e = qb.pop_front();
          if (256'(b_m_tdata) !== e.data || 8'(b_m_tkeep) !== e.keep ||
              b_m_tlast !== e.last || b_m_tuser !== e.user) begin
            n_fail++;
            $display("FAIL b_beat: got data=%h keep=%b last=%b user=%b want data=%h keep=%b last=%b user=%b",
                     b_m_tdata, b_m_tkeep, b_m_tlast, b_m_tuser, e.data[239:0], e.keep[5:0],
                     e.last, e.user);
          end
        end
      end
      if (b_s_tvalid && b_s_tready) begin
        model_accept(1, 4, 2, 3, 256'(b_s_tdata), b_s_tlast, b_s_tuser, l, e);
        if (l) qb.push_back(e);
      end
    end
  end

  function automatic logic [29:0] pa(input logic [9:0] v);
    return {v + 10'h200, v + 10'h100, v};
  endfunction

  function automatic logic [9:0] wb(input int c, input int n, input int p);
    return 10'(c * 100 + n * 2 + p);
  endfunction

  function automatic logic [79:0] pb(input int n);
    logic [79:0] r;
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 2; p++) r[(c*2 + p)*10 +: 10] = wb(c, n, p);
    return r;
  endfunction

  // Offer one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic drive_a(input logic [29:0] d, input logic last, input logic user);
    a_s_tdata = d; a_s_tlast = last; a_s_tuser = user; a_s_tvalid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (a_s_tready) begin
        @(posedge clk); #1;
        a_s_tvalid = 1'b0; a_s_tlast = 1'b0; a_s_tuser = 1'b0;
        return;
      end
    end
    n_vec++; n_fail++;
    $display("FAIL drive_a_timeout: got no s_tready in 60 cycles, want accept");
    a_s_tvalid = 1'b0;
  endtask

  task automatic drive_b(input logic [79:0] d, input logic last, input logic user);
    b_s_tdata = d; b_s_tlast = last; b_s_tuser = user; b_s_tvalid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (b_s_tready) begin
        @(posedge clk); #1;
        b_s_tvalid = 1'b0; b_s_tlast = 1'b0; b_s_tuser = 1'b0;
        return;
      end
    end
    n_vec++; n_fail++;
    $display("FAIL drive_b_timeout: got no s_tready in 60 cycles, want accept");
    b_s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    a_s_tvalid = 0; a_s_tlast = 0; a_s_tuser = 0; a_s_tdata = '0; a_m_tready = 1'b1;
    b_s_tvalid = 0; b_s_tlast = 0; b_s_tuser = 0; b_s_tdata = '0; b_m_tready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({a_m_tvalid, a_m_tdata, a_m_tkeep, a_m_tlast, a_m_tuser, a_misalign, a_s_tready} !== '0) begin
      n_fail++;
      $display("FAIL reset_a_outputs: got v=%b d=%h k=%b l=%b u=%b m=%b r=%b want all 0",
               a_m_tvalid, a_m_tdata, a_m_tkeep, a_m_tlast, a_m_tuser, a_misalign, a_s_tready);
    end
    n_vec++;
    if ({b_m_tvalid, b_m_tdata, b_m_tkeep, b_m_tlast, b_m_tuser, b_misalign, b_s_tready} !== '0) begin
      n_fail++;
      $display("FAIL reset_b_outputs: got v=%b k=%b r=%b want all 0", b_m_tvalid, b_m_tkeep, b_s_tready);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_vec++;
    if (a_s_tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_before_edge: got %b want 0", a_s_tready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (a_s_tready !== 1'b1 || b_s_tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after_edge: got a=%b b=%b want 1 1", a_s_tready, b_s_tready);
    end
  endtask

  task automatic test_basic();
    drive_a(pa(10'h001), 0, 0);
    n_vec++;
    if (a_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_beat: got %b want 0", a_m_tvalid); end
    drive_a(pa(10'h002), 0, 0);
    n_vec++;
    if (a_m_tvalid !== 1'b1 || a_m_tkeep !== 2'b11 ||
        a_m_tdata !== {10'h202, 10'h201, 10'h102, 10'h101, 10'h002, 10'h001}) begin
      n_fail++;
      $display("FAIL basic_first_beat: got v=%b k=%b d=%h want v=1 k=11 d=202/201/102/101/002/001",
               a_m_tvalid, a_m_tkeep, a_m_tdata);
    end
    drive_a(pa(10'h003), 0, 0);
    n_vec++;
    if (a_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_gap: got %b want 0", a_m_tvalid); end
    drive_a(pa(10'h004), 0, 0);
    n_vec++;
    if (a_m_tvalid !== 1'b1 || a_m_tdata[0] !== {10'h004, 10'h003}) begin
      n_fail++; $display("FAIL basic_second_beat: got v=%b ch0=%h want v=1 ch0=004/003", a_m_tvalid, a_m_tdata[0]);
    end
    for (int v = 5; v <= 8; v++) drive_a(pa(10'(v)), 0, 0);
    idle(3);
  endtask

  task automatic test_realign();
    drive_a(pa(10'h00A), 0, 0);
    drive_a(pa(10'h00B), 0, 1);
    n_vec++;
    if (a_misalign !== 1'b1 || a_m_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL realign_pulse: got mis=%b v=%b want mis=1 v=0", a_misalign, a_m_tvalid);
    end
    drive_a(pa(10'h00C), 0, 0);
    n_vec++;
    if (a_misalign !== 1'b0 || a_m_tvalid !== 1'b1 || a_m_tuser !== 1'b1 ||
        a_m_tdata[0] !== {10'h00C, 10'h00B}) begin
      n_fail++;
      $display("FAIL realign_beat: got mis=%b v=%b u=%b ch0=%h want mis=0 v=1 u=1 ch0=00C/00B",
               a_misalign, a_m_tvalid, a_m_tuser, a_m_tdata[0]);
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    logic [59:0] snap;
    bit have;
    have = 0;
    snap = '0;
    a_m_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) drive_a(pa(10'(10'h030 + i)), 0, 0);
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (a_m_tvalid) begin
            if (!have) begin
              snap = a_m_tdata; have = 1;
            end else begin
              n_vec++;
              if (a_m_tdata !== snap || a_s_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: got d=%h rdy=%b want d=%h rdy=0", a_m_tdata, a_s_tready, snap);
              end
            end
          end
        end
        n_vec++;
        if (have !== 1'b1) begin n_fail++; $display("FAIL backpressure_fill: got %b want 1", have); end
        @(posedge clk); #1;
        a_m_tready = 1'b1;
      end
    join
    idle(3);
  endtask

  task automatic test_reset_mid();
    drive_a(pa(10'h050), 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    model_clear();
    n_vec++;
    if ({a_m_tvalid, a_m_tdata, a_m_tkeep, a_m_tlast, a_m_tuser, a_misalign, a_s_tready} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got v=%b d=%h r=%b want all 0", a_m_tvalid, a_m_tdata, a_s_tready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (a_s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b want 1", a_s_tready); end
    drive_a(pa(10'h060), 0, 0);
    drive_a(pa(10'h061), 0, 0);
    n_vec++;
    if (a_m_tvalid !== 1'b1 || a_m_tdata[0] !== {10'h061, 10'h060}) begin
      n_fail++; $display("FAIL reset_mid_first_beat: got v=%b ch0=%h want v=1 ch0=061/060", a_m_tvalid, a_m_tdata[0]);
    end
    idle(3);
  endtask

  task automatic test_flush();
    logic pad_ok;
    drive_b(pb(0), 0, 0);
    drive_b(pb(1), 1, 0);
    pad_ok = 1'b1;
    for (int c = 0; c < 4; c++)
      if (b_m_tdata[c][4] !== PAD || b_m_tdata[c][5] !== PAD) pad_ok = 1'b0;
    n_vec++;
    if (b_m_tvalid !== 1'b1 || b_m_tkeep !== 6'b001111 || b_m_tlast !== 1'b1 || pad_ok !== 1'b1 ||
        b_m_tdata[0][2] !== wb(0, 1, 0)) begin
      n_fail++;
      $display("FAIL flush_beat: got v=%b k=%b l=%b pad=%b w2=%h want v=1 k=001111 l=1 pad=1 w2=%h",
               b_m_tvalid, b_m_tkeep, b_m_tlast, pad_ok, b_m_tdata[0][2], wb(0, 1, 0));
    end
    drive_b(pb(2), 0, 0);
    drive_b(pb(3), 0, 0);
    drive_b(pb(4), 0, 0);
    n_vec++;
    if (b_m_tkeep !== 6'b111111 || b_m_tlast !== 1'b0 || b_m_tdata[3][0] !== wb(3, 2, 0)) begin
      n_fail++;
      $display("FAIL flush_next_group: got k=%b l=%b w0=%h want k=111111 l=0 w0=%h",
               b_m_tkeep, b_m_tlast, b_m_tdata[3][0], wb(3, 2, 0));
    end
    drive_b(pb(5), 0, 0);
    drive_b(pb(6), 1, 1);
    n_vec++;
    if (b_m_tkeep !== 6'b000011 || b_m_tlast !== 1'b1 || b_m_tuser !== 1'b1 ||
        b_misalign !== 1'b1 || b_m_tdata[0][0] !== wb(0, 6, 0)) begin
      n_fail++;
      $display("FAIL flush_user_last: got k=%b l=%b u=%b mis=%b w0=%h want k=000011 l=1 u=1 mis=1 w0=%h",
               b_m_tkeep, b_m_tlast, b_m_tuser, b_misalign, b_m_tdata[0][0], wb(0, 6, 0));
    end
    idle(3);
  endtask

  task automatic test_random();
    logic acc;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      acc = b_s_tvalid && b_s_tready;
      @(posedge clk); #1;
      if (!b_s_tvalid || acc) begin
        b_s_tvalid = 1'($urandom_range(0, 1));
        b_s_tdata  = 80'({$urandom, $urandom, $urandom});
        b_s_tlast  = ($urandom_range(0, 4) == 0);
        b_s_tuser  = ($urandom_range(0, 9) == 0);
      end
      b_m_tready = 1'($urandom_range(0, 1));
    end
    b_m_tready = 1'b1;
    if (b_s_tvalid) drive_b(b_s_tdata, b_s_tlast, b_s_tuser);
    idle(6);
    n_vec++;
    if (qb.size() != 0 || qa.size() != 0) begin
      n_fail++; $display("FAIL drain: got qa=%0d qb=%0d pending beats want 0 0", qa.size(), qb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_realign();
    test_backpressure();
    test_reset_mid();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 want finish");
    $fatal(1);
  end

endmodule

// File: doc/hdmi_tx_tmds_packer.md
# hdmi_tx_tmds_packer

Parametrised TMDS beat packer: it collects RATIO consecutive input beats of PIX_IN TMDS words per channel into one output beat of PIX_IN*RATIO words per channel. It sits between hdmi_tx_core and the clock-domain-crossing AFIFO on the TMDS path. It generalises the fixed 1-to-2 pixel deserializer to any channel count and ratio. It adds AXI-S backpressure on both sides, end-of-line flush with a keep mask, and start-of-frame realignment.

## Interface
Parameters:
- TMDS_DATA_WIDTH, 10, bits per TMDS word
- CH_NUM, 3, TMDS channels packed in lockstep (ch0 B/Cb, ch1 G/Y, ch2 R/Cr)
- PIX_IN, 1, words per channel per input beat (≥1)
- RATIO, 2, input beats per output beat (≥2); PIX_OUT = PIX_IN*RATIO (localparam)
- PAD_WORD, 10'b1101010100, TMDS word used to fill unused slots of a flushed beat (CTL0 token)

Ports. One clock; reset is asynchronous and active-low.
- clk_i  in  1  TMDS-side pixel clock
- rstn_i  in  1  asynchronous reset, active low
- s_tvalid_i  in  1  input beat valid
- s_tready_o  out  1  input beat ready
- s_tdata_i  in  [CH_NUM][PIX_IN][TMDS_DATA_WIDTH]  input TMDS words
- s_tlast_i  in  1  last beat of line; forces flush
- s_tuser_i  in  1  first beat of frame; forces realignment to slot 0
- m_tvalid_o  out  1  output beat valid
- m_tready_i  in  1  output beat ready
- m_tdata_o  out  [CH_NUM][PIX_OUT][TMDS_DATA_WIDTH]  packed TMDS words
- m_tkeep_o  out  PIX_OUT  per-word valid mask (common to all channels)
- m_tlast_o  out  1  beat contains end of line
- m_tuser_o  out  1  beat contains start of frame
- misalign_o  out  1  one-cycle pulse: a partial accumulation was discarded by s_tuser_i

## Operation
- Slot counter cnt counts 0..RATIO-1, width $clog2(RATIO). Accumulator holds slots 0..RATIO-2. An output register holds one packed beat.
- Placement: the input beat accepted at slot k writes m_tdata_o[ch][k*PIX_IN + p] for p = 0..PIX_IN-1. The earliest beat takes the lowest indices.
- Handshake: transfer happens when valid && ready. Input and output are independent.
- s_tready_o = rdy_en && (out_free || m_tready_i), where out_free = !m_tvalid_o. This holds for every slot, which keeps the ready logic uniform. s_tready_o does not depend on s_tvalid_i.
- Launch condition: an accepted beat with cnt == RATIO-1, or with s_tlast_i = 1. On launch:
  - The output register loads the accumulator plus the current beat.
  - Words in slots above the current slot are set to PAD_WORD.
  - m_tkeep_o = (cnt+1)*PIX_IN low bits set.
  - m_tlast_o = s_tlast_i.
  - m_tuser_o = 1 if any beat of this group had s_tuser_i.
  - cnt returns to 0.
- Non-launch accept: the beat is stored in slot cnt, then cnt++.
- Realignment: an accepted beat with s_tuser_i = 1 and cnt != 0 causes three things:
  - The pending slots are discarded, with no output.
  - The beat is placed at slot 0 and cnt becomes 1.
  - misalign_o pulses in the next cycle.
- s_tuser_i and s_tlast_i on the same beat: realign first, then flush. The result is a one-slot beat with tkeep = PIX_IN ones, tuser = 1, tlast = 1.
- Output register: holds while m_tvalid_o && !m_tready_i. All m_* outputs stay stable until accepted.

## Timing
- Reset values: m_tvalid_o, m_tlast_o, m_tuser_o, misalign_o = 0; m_tkeep_o = 0; m_tdata_o = 0; cnt = 0.
- rdy_en = 0 in reset, so s_tready_o = 0. It goes to 1 on the first clk_i edge after rstn_i deasserts.
- Latency: launching beat accepted at edge t -> m_tvalid_o high after edge t, i.e. visible in cycle t+1.
- Throughput: one input beat per cycle when m_tready_i = 1, which gives one output beat every RATIO cycles. There are no bubbles.
- Simultaneous output accept and new launch in the same cycle: the output register reloads and m_tvalid_o stays 1.
- Reset mid-operation: the accumulator, cnt, and output register are cleared asynchronously. The partial group is lost and no beat is emitted.

## Structure
- Shared package hdmi_tx_pkg holds:
  - localparam TMDS_DATA_WIDTH;
  - the TMDS control tokens CTL0..CTL3 (PAD_WORD defaults to CTL0);
  - typedef tmds_word_t.
- One module; no sub-module is needed. The output register is inline and mirrors the gp_afifo_buf input contract.

## Test plan
- Default params, 8 continuous beats 0x001..0x008 on ch0 (ch1 = +0x100, ch2 = +0x200), m_tready_i = 1:
  - 4 output beats; ch0 {0x002,0x001}, {0x004,0x003}, ...;
  - tkeep = 2'b11; one output every 2 cycles, first in cycle t+1.
- RATIO = 4, PIX_IN = 1, s_tlast_i on the 3rd beat:
  - one beat with slot 3 = 10'b1101010100 on all channels;
  - tkeep = 4'b0111, tlast = 1; cnt = 0 afterwards.
- s_tuser_i on the beat after a single pending beat (RATIO = 2):
  - misalign_o pulses once and the pending word is absent from the output;
  - the next output carries the tuser beat in slot 0 with m_tuser_o = 1.
- Hold m_tready_i = 0 for 10 cycles while driving continuous input:
  - s_tready_o drops after the output register fills;
  - m_tdata_o stays stable; no word is lost or duplicated once ready returns.
- Assert rstn_i mid-group, then release:
  - all outputs are 0 and s_tready_o = 0 during reset, and s_tready_o is 1 after one edge;
  - the first output contains only post-reset data.
- Random valid/ready (50%), CH_NUM = 4, PIX_IN = 2, RATIO = 3, against a scoreboard model: every word appears in order, and tkeep/tlast/tuser match.
